mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data-side MMIO bus, directly downstream of cpu_top.
- Consumes the core's MMIO write strobes (addr/data/mask/wren) and serialises bytes as 8N1 on a TX pin.
- Provides a combinational read path (status, divisor) back into the core's MMIO read-data input.
- Contains a small byte FIFO so firmware can issue back-to-back stores without polling every byte.

---
 rtl/mmio_uart_defs.sv | 28 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/mmio_uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_defs.sv
// Shared definitions for the MMIO UART transmitter: register indices,
// STATUS bit positions and the serialiser state encoding.
package mmio_uart_defs;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;
   localparam logic [1:0] REG_IRQ_EN  = 2'd3;

   localparam int STAT_BUSY      = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_EMPTY     = 2;
   localparam int STAT_OVERFLOW  = 3;
   localparam int STAT_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Baud counter counts down to zero; a divisor of 0 is treated as 1.
   function automatic logic [15:0] bit_reload(input logic [15:0] div);
      return (div == 16'd0) ? 16'd0 : div - 16'd1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO with first-word-fall-through output.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and combinational read path.
// Define MMIO_UART_TX_IRQ_EN to add the o_irq output and a writable IRQ_EN register.
module mmio_uart_tx
   import mmio_uart_defs::*;
#(
   parameter logic [29:0] BASE_ADDR  = 30'h0400_0000,
   parameter int          FIFO_DEPTH = 8,
   parameter int          CLK_DIV    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [29:0] i_mmio_addr,
   input  logic [31:0] i_mmio_data,
   input  logic [3:0]  i_mmio_mask,
   input  logic        i_mmio_wren,
   output logic [31:0] o_mmio_data,
`ifdef MMIO_UART_TX_IRQ_EN
   output logic        o_irq,
`endif
   output logic        o_tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic          sel;
   logic          wr;
   logic [1:0]    reg_idx;
   logic          push_req;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [7:0]    fifo_dout;
   logic [15:0]   divisor;
   logic          overflow;
   logic [31:0]   status;
   tx_state_t     state;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          unused_bits;
`ifdef MMIO_UART_TX_IRQ_EN
   logic          irq_en;
`endif

   assign sel      = (i_mmio_addr[29:2] == BASE_ADDR[29:2]);
   assign reg_idx  = i_mmio_addr[1:0];
   assign wr       = i_mmio_wren && sel;
   assign push_req = wr && (reg_idx == REG_TXDATA) && i_mmio_mask[0];

   // The FIFO is drained when idle, or at the last cycle of STOP so frames run back to back.
   assign pop = !empty && ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == 16'd0)));

   assign unused_bits = ^{i_mmio_data[31:16], i_mmio_mask[3:2]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_req),
      .pop   (pop),
      .din   (i_mmio_data[7:0]),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divisor  <= 16'(CLK_DIV);
         overflow <= 1'b0;
`ifdef MMIO_UART_TX_IRQ_EN
         irq_en   <= 1'b0;
`endif
      end else begin
         if (push_req && full && !pop) begin
            overflow <= 1'b1;
         end else if (wr && (reg_idx == REG_STATUS) && i_mmio_mask[0] && i_mmio_data[STAT_OVERFLOW]) begin
            overflow <= 1'b0;
         end
         if (wr && (reg_idx == REG_DIVISOR)) begin
            if (i_mmio_mask[0]) divisor[7:0]  <= i_mmio_data[7:0];
            if (i_mmio_mask[1]) divisor[15:8] <= i_mmio_data[15:8];
         end
`ifdef MMIO_UART_TX_IRQ_EN
         if (wr && (reg_idx == REG_IRQ_EN) && i_mmio_mask[0]) begin
            irq_en <= i_mmio_data[0];
         end
`endif
      end
   end

   always_comb begin
      status = '0;
      status[STAT_BUSY]     = (state != ST_IDLE);
      status[STAT_FULL]     = full;
      status[STAT_EMPTY]    = empty;
      status[STAT_OVERFLOW] = overflow;
      status[STAT_COUNT_LSB +: 8] = 8'(count);
   end

   always_comb begin
      o_mmio_data = '0;
      if (sel) begin
         case (reg_idx)
            REG_STATUS:  o_mmio_data = status;
            REG_DIVISOR: o_mmio_data = {16'd0, divisor};
`ifdef MMIO_UART_TX_IRQ_EN
            REG_IRQ_EN:  o_mmio_data = {31'd0, irq_en};
`endif
            default:     o_mmio_data = '0;
         endcase
      end
   end

   // Serialiser: every state and every data bit lasts bit_reload(divisor)+1 cycles,
   // with the divisor sampled only at boundaries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         o_tx      <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shift_reg <= fifo_dout;
                  baud_cnt  <= bit_reload(divisor);
                  bit_cnt   <= '0;
                  o_tx      <= 1'b0;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= bit_reload(divisor);
                  o_tx     <= shift_reg[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            ST_DATA: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= bit_reload(divisor);
                  if (bit_cnt == 3'd7) begin
                     o_tx  <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     o_tx      <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            ST_STOP: begin
               if (baud_cnt == 16'd0) begin
                  if (pop) begin
                     shift_reg <= fifo_dout;
                     baud_cnt  <= bit_reload(divisor);
                     bit_cnt   <= '0;
                     o_tx      <= 1'b0;
                     state     <= ST_START;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
               o_tx  <= 1'b1;
            end
         endcase
      end
   end

`ifdef MMIO_UART_TX_IRQ_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_irq <= 1'b0;
      end else begin
         o_irq <= irq_en && empty && (state == ST_IDLE);
      end
   end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx: register access, frame timing, FIFO
// back-to-back and overflow behaviour, async reset, and the optional interrupt.
module tb_mmio_uart_tx;
   import mmio_uart_defs::*;

   localparam logic [29:0] BASE = 30'h0400_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [29:0] addr;
   logic [31:0] data;
   logic [3:0]  mask;
   logic        wren;
   logic [31:0] rdata;
   logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;

   mmio_uart_tx #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (8),
      .CLK_DIV    (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_mmio_addr (addr),
      .i_mmio_data (data),
      .i_mmio_mask (mask),
      .i_mmio_wren (wren),
      .o_mmio_data (rdata),
`ifdef MMIO_UART_TX_IRQ_EN
      .o_irq       (irq),
`endif
      .o_tx        (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [29:0] reg_addr(input logic [1:0] idx);
      return BASE | 30'(idx);
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx == 9) return 1'b1;
      return b[idx-1];
   endfunction

   // Called just after a falling edge; the write is captured at the next rising edge.
   task automatic write_reg(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] m);
      addr = reg_addr(idx);
      data = d;
      mask = m;
      wren = 1'b1;
      @(negedge clk);
      wren = 1'b0;
      mask = 4'b0000;
   endtask

   task automatic read_reg(input logic [29:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic send_frame(input logic [7:0] b, input int div, input string name);
      logic [31:0] v;
      write_reg(REG_TXDATA, {24'd0, b}, 4'b0001);
      @(posedge clk);
      @(negedge clk);
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (v !== 32'h0000_0005) begin
         errors++;
         $display("[TB] FAIL %s_status_start: got %h expected %h", name, v, 32'h5);
      end
      for (int k = 0; k < 10 * div; k++) begin
         checks++;
         if (tx !== frame_bit(b, k / div)) begin
            errors++;
            $display("[TB] FAIL %s_tx cycle %0d: got %b expected %b", name, k, tx, frame_bit(b, k / div));
         end
         @(negedge clk);
      end
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (tx !== 1'b1 || v !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL %s_end: got tx=%b status=%h expected tx=1 status=%h", name, tx, v, 32'h4);
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst_n = 1'b0;
      addr  = BASE;
      data  = '0;
      mask  = '0;
      wren  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_tx_in_reset: got %b expected 1", tx);
      end
      rst_n = 1'b1;
      @(negedge clk);
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (v !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL reset_status: got %h expected %h", v, 32'h4);
      end
      read_reg(reg_addr(REG_DIVISOR), v);
      checks++;
      if (v !== 32'd16) begin
         errors++;
         $display("[TB] FAIL reset_divisor: got %h expected %h", v, 32'd16);
      end
      read_reg(reg_addr(REG_TXDATA), v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_txdata_read: got %h expected 0", v);
      end
      read_reg(reg_addr(REG_IRQ_EN), v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_irq_en: got %h expected 0", v);
      end
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_tx: got %b expected 1", tx);
      end
   endtask

   task automatic test_registers();
      logic [31:0] v;
      logic [31:0] irq_exp;
      @(negedge clk);
      write_reg(REG_TXDATA, 32'h0000_0055, 4'b1110);
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (v !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL masked_push_status: got %h expected %h", v, 32'h4);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL masked_push_tx: got %b expected 1", tx);
      end
      read_reg(BASE + 30'd4, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("[TB] FAIL unselected_read_hi: got %h expected 0", v);
      end
      read_reg(30'h0000_0001, v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("[TB] FAIL unselected_read_lo: got %h expected 0", v);
      end
      @(negedge clk);
      write_reg(REG_DIVISOR, 32'h0000_1234, 4'b0010);
      read_reg(reg_addr(REG_DIVISOR), v);
      checks++;
      if (v !== 32'h0000_1210) begin
         errors++;
         $display("[TB] FAIL divisor_byte1: got %h expected %h", v, 32'h1210);
      end
      write_reg(REG_DIVISOR, 32'h0000_5678, 4'b0001);
      read_reg(reg_addr(REG_DIVISOR), v);
      checks++;
      if (v !== 32'h0000_1278) begin
         errors++;
         $display("[TB] FAIL divisor_byte0: got %h expected %h", v, 32'h1278);
      end
      write_reg(REG_DIVISOR, 32'hFFFF_0004, 4'b1111);
      read_reg(reg_addr(REG_DIVISOR), v);
      checks++;
      if (v !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL divisor_full: got %h expected %h", v, 32'h4);
      end
      write_reg(REG_IRQ_EN, 32'h0000_0001, 4'b0001);
      read_reg(reg_addr(REG_IRQ_EN), v);
`ifdef MMIO_UART_TX_IRQ_EN
      irq_exp = 32'd1;
`else
      irq_exp = 32'd0;
`endif
      checks++;
      if (v !== irq_exp) begin
         errors++;
         $display("[TB] FAIL irq_en_rw: got %h expected %h", v, irq_exp);
      end
      write_reg(REG_IRQ_EN, 32'h0000_0000, 4'b0001);
   endtask

   task automatic test_single_frame();
      @(negedge clk);
      write_reg(REG_DIVISOR, 32'd4, 4'b0011);
      send_frame(8'h55, 4, "frame55");
   endtask

   task automatic test_divisor_zero();
      logic [31:0] v;
      @(negedge clk);
      write_reg(REG_DIVISOR, 32'd0, 4'b0011);
      read_reg(reg_addr(REG_DIVISOR), v);
      checks++;
      if (v !== 32'd0) begin
         errors++;
         $display("[TB] FAIL divisor_zero_read: got %h expected 0", v);
      end
      @(negedge clk);
      send_frame(8'hA5, 1, "div0");
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic [7:0]  bytes [3];
      logic        exp;
      bytes[0] = 8'h01;
      bytes[1] = 8'h02;
      bytes[2] = 8'h03;
      @(negedge clk);
      write_reg(REG_DIVISOR, 32'd4, 4'b0011);
      for (int i = 0; i < 3; i++) begin
         write_reg(REG_TXDATA, {24'd0, bytes[i]}, 4'b0001);
      end
      for (int k = 1; k < 120; k++) begin
         if (k == 1 || k == 40 || k == 80) begin
            read_reg(reg_addr(REG_STATUS), v);
            checks++;
            if (k == 1 && v !== 32'h0000_0201) begin
               errors++;
               $display("[TB] FAIL b2b_count2: got %h expected %h", v, 32'h201);
            end else if (k == 40 && v !== 32'h0000_0101) begin
               errors++;
               $display("[TB] FAIL b2b_count1: got %h expected %h", v, 32'h101);
            end else if (k == 80 && v !== 32'h0000_0005) begin
               errors++;
               $display("[TB] FAIL b2b_count0: got %h expected %h", v, 32'h5);
            end
         end
         exp = frame_bit(bytes[k / 40], (k % 40) / 4);
         checks++;
         if (tx !== exp) begin
            errors++;
            $display("[TB] FAIL b2b_tx cycle %0d: got %b expected %b", k, tx, exp);
         end
         @(negedge clk);
      end
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (tx !== 1'b1 || v !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL b2b_end: got tx=%b status=%h expected tx=1 status=%h", tx, v, 32'h4);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      @(negedge clk);
      write_reg(REG_DIVISOR, 32'd16, 4'b0011);
      for (int i = 0; i < 10; i++) begin
         write_reg(REG_TXDATA, 32'h10 + 32'(i), 4'b0001);
      end
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (v !== 32'h0000_080B) begin
         errors++;
         $display("[TB] FAIL overflow_status: got %h expected %h", v, 32'h80B);
      end
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overflow_start_bit: got %b expected 0", tx);
      end
      @(negedge clk);
      write_reg(REG_STATUS, 32'h0000_0008, 4'b0001);
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (v !== 32'h0000_0803) begin
         errors++;
         $display("[TB] FAIL overflow_w1c: got %h expected %h", v, 32'h803);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] v;
      @(negedge clk);
      write_reg(REG_DIVISOR, 32'd7, 4'b0011);
      repeat (8) @(negedge clk);
      read_reg(reg_addr(REG_DIVISOR), v);
      checks++;
      if (v !== 32'd7) begin
         errors++;
         $display("[TB] FAIL midframe_divisor: got %h expected 7", v);
      end
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midframe_data_bit0: got %b expected 0", tx);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("[TB] FAIL async_reset_tx: got %b expected 1", tx);
      end
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (v !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL async_reset_status: got %h expected %h", v, 32'h4);
      end
      read_reg(reg_addr(REG_DIVISOR), v);
      checks++;
      if (v !== 32'd16) begin
         errors++;
         $display("[TB] FAIL async_reset_divisor: got %h expected %h", v, 32'd16);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      read_reg(reg_addr(REG_STATUS), v);
      checks++;
      if (tx !== 1'b1 || v !== 32'h0000_0004) begin
         errors++;
         $display("[TB] FAIL after_reset_idle: got tx=%b status=%h expected tx=1 status=%h", tx, v, 32'h4);
      end
   endtask

`ifdef MMIO_UART_TX_IRQ_EN
   task automatic test_irq();
      @(negedge clk);
      write_reg(REG_DIVISOR, 32'd4, 4'b0011);
      write_reg(REG_IRQ_EN, 32'd1, 4'b0001);
      @(negedge clk);
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_idle: got %b expected 1", irq);
      end
      write_reg(REG_TXDATA, 32'h0000_00C3, 4'b0001);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 42; k++) begin
         if (k == 5 || k == 30) begin
            checks++;
            if (irq !== 1'b0) begin
               errors++;
               $display("[TB] FAIL irq_during_frame cycle %0d: got %b expected 0", k, irq);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++;
         $display("[TB] FAIL irq_after_frame: got %b expected 1", irq);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_registers();
      test_single_frame();
      test_divisor_zero();
      test_back_to_back();
      test_overflow();
      test_reset_mid_frame();
`ifdef MMIO_UART_TX_IRQ_EN
      test_irq();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
